fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 21 ++
 rtl/fetch_unit_pc_reg.sv | 29 ++
 rtl/fetch_unit.sv | 102 ++++++++++
 tb/tb_fetch_unit.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_unit_pkg;

  typedef enum logic {
    FETCH = 1'b0,
    VALID = 1'b1
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
  localparam logic [31:0] IMEM_LO_DEFAULT  = 32'h0000_3000;
  localparam logic [31:0] IMEM_HI_DEFAULT  = 32'h0000_6FFC;
  localparam logic [31:0] NOP              = 32'h0000_0000;

  // True when a fetch address is misaligned or outside the instruction window.
  function automatic logic fetch_addr_bad(input logic [31:0] addr,
                                          input logic [31:0] lo,
                                          input logic [31:0] hi);
    return (addr[1:0] != 2'b00) || (addr < lo) || (addr > hi);
  endfunction

endpackage

// File: rtl/fetch_unit_pc_reg.sv
// Program counter register: 32-bit, async reset to RESET_PC, loads d when load_en.
module pc_reg
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_en,
  input  logic [31:0] d,
  output logic [31:0] q
);

  logic [31:0] pc_d;
  logic [31:0] pc_q;

  always_comb begin
    pc_d = pc_q;
    if (load_en) pc_d = d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pc_q <= RESET_PC;
    else       pc_q <= pc_d;
  end

  assign q = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Two-state instruction fetch unit (FETCH -> VALID -> FETCH).
// Optional address checking is enabled by defining FETCH_ADDR_CHECK_EN.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [31:0] IMEM_LO  = IMEM_LO_DEFAULT,
  parameter logic [31:0] IMEM_HI  = IMEM_HI_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] npc,
  input  logic        stall,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic [31:0] pc,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic        exc_adel
);

`ifdef FETCH_ADDR_CHECK_EN
  localparam logic ADDR_CHECK_EN = 1'b1;
`else
  localparam logic ADDR_CHECK_EN = 1'b0;
`endif

  fetch_state_e state_d, state_q;
  logic [31:0]  instr_d, instr_q;
  logic         instr_valid_d, instr_valid_q;
  logic         exc_adel_d, exc_adel_q;
  logic         pc_load;
  logic         addr_err;

  pc_reg #(
    .RESET_PC(RESET_PC)
  ) u_pc_reg (
    .clk    (clk),
    .reset  (reset),
    .load_en(pc_load),
    .d      (npc),
    .q      (pc)
  );

  assign addr_err = ADDR_CHECK_EN && fetch_addr_bad(pc, IMEM_LO, IMEM_HI);

  // A faulting address completes the fetch immediately with a NOP and the error flag.
  always_comb begin
    state_d       = state_q;
    instr_d       = instr_q;
    instr_valid_d = instr_valid_q;
    exc_adel_d    = exc_adel_q;
    pc_load       = 1'b0;
    case (state_q)
      FETCH: begin
        if (addr_err) begin
          state_d       = VALID;
          instr_d       = NOP;
          instr_valid_d = 1'b1;
          exc_adel_d    = 1'b1;
        end else if (imem_ready) begin
          state_d       = VALID;
          instr_d       = imem_rdata;
          instr_valid_d = 1'b1;
          exc_adel_d    = 1'b0;
        end
      end
      VALID: begin
        if (!stall) begin
          state_d       = FETCH;
          pc_load       = 1'b1;
          instr_valid_d = 1'b0;
          exc_adel_d    = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= FETCH;
      instr_q       <= NOP;
      instr_valid_q <= 1'b0;
      exc_adel_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      exc_adel_q    <= exc_adel_d;
    end
  end

  // Reset gates the request combinationally so it drops without waiting for an edge.
  assign imem_req    = (state_q == FETCH) && !reset && !addr_err;
  assign imem_addr   = pc;
  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;
  assign exc_adel    = exc_adel_q & ADDR_CHECK_EN;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: random ready/stall/npc, transaction-level reference model.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam logic [31:0] IMEM_LO  = 32'h0000_3000;
  localparam logic [31:0] IMEM_HI  = 32'h0000_6FFC;
`ifdef FETCH_ADDR_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] npc;
  logic        stall;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        instr_valid;
  logic        exc_adel;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic        exc;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        cur;
  int          vectors     = 0;
  int          miscompares = 0;
  int          retired     = 0;
  logic [31:0] last_addr;
  bit          hold_at_3010 = 1'b0;
  bit          mon_en       = 1'b0;
  bit          prev_valid   = 1'b0;
  bit          have_pred    = 1'b0;
  bit          pred_valid   = 1'b0;

  fetch_unit #(
    .RESET_PC(RESET_PC),
    .IMEM_LO (IMEM_LO),
    .IMEM_HI (IMEM_HI)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .npc        (npc),
    .stall      (stall),
    .imem_rdata (imem_rdata),
    .imem_ready (imem_ready),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .pc         (pc),
    .instr      (instr),
    .instr_valid(instr_valid),
    .exc_adel   (exc_adel)
  );

  always #5 clk = ~clk;

  // Instruction memory contents; the reset address holds 32'h3C01_0001.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return ((a - 32'h0000_3000) * 32'h9E37_79B1) ^ 32'h3C01_0001;
  endfunction

  function automatic bit addr_bad(input logic [31:0] a);
    return CHECK_EN && (((a % 4) != 0) || (a < IMEM_LO) || (a > IMEM_HI));
  endfunction

  function automatic exp_t make_exp(input logic [31:0] a);
    exp_t e;
    e.addr = a;
    e.exc  = addr_bad(a);
    e.data = e.exc ? 32'h0 : mem_word(a);
    return e;
  endfunction

  function automatic logic [31:0] pick_npc(input logic [31:0] prev);
    int r;
    r = $urandom_range(0, 19);
    if (r < 12) return prev + 32'd4;
    if (r < 16) return IMEM_LO + (32'($urandom_range(0, 32'h0FFF)) << 2);
    if (r == 16) return 32'hFFFF_FFFC;
    if (r == 17) return 32'h0000_0000;
    if (r == 18) return 32'h0000_3002;
    return 32'h0000_7000;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic checkResetState();
    checkOutput("rst_pc", pc, RESET_PC);
    checkOutput("rst_addr", imem_addr, RESET_PC);
    checkOutput("rst_instr", instr, 32'h0);
    checkOutput("rst_valid", 32'(instr_valid), 32'h0);
    checkOutput("rst_exc", 32'(exc_adel), 32'h0);
    checkOutput("rst_req", 32'(imem_req), 32'h0);
  endtask

  // Acts as both the next-PC logic and the instruction memory.
  task automatic applyStimulus();
    logic [31:0] nxt;
    stall      = ($urandom_range(0, 9) < 4);
    imem_ready = ($urandom_range(0, 9) < 6);
    npc        = $urandom;
    imem_rdata = $urandom;
    if (instr_valid) begin
      if (hold_at_3010) stall = 1'b0;
      if (!stall) begin
        nxt       = hold_at_3010 ? 32'h0000_3010 : pick_npc(last_addr);
        npc       = nxt;
        last_addr = nxt;
        exp_q.push_back(make_exp(nxt));
      end
    end else begin
      if (hold_at_3010 && imem_addr == 32'h0000_3010) imem_ready = 1'b0;
      if (imem_ready) imem_rdata = mem_word(imem_addr);
    end
  endtask

  task automatic runRandom(input int target, input int budget);
    int c;
    c = 0;
    while (retired < target && c < budget) begin
      @(posedge clk);
      #1;
      applyStimulus();
      c++;
    end
    if (retired < target) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL timeout: got %0d retired, expected %0d", retired, target);
    end
  endtask

  task automatic restartAfterReset();
    exp_q.delete();
    last_addr = RESET_PC;
    exp_q.push_back(make_exp(RESET_PC));
    prev_valid = 1'b0;
    have_pred  = 1'b0;
    imem_ready = 1'b1;
    imem_rdata = mem_word(RESET_PC);
    stall      = 1'b0;
    reset      = 1'b0;
  endtask

  // Monitor: pops one expected transaction per instr_valid rise and checks every cycle.
  always @(negedge clk) begin
    if (mon_en && !reset) begin
      if (have_pred) checkOutput("valid_timing", 32'(instr_valid), 32'(pred_valid));
      if (instr_valid) begin
        if (!prev_valid) begin
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL unexpected_valid: got valid, expected no transaction");
          end else begin
            cur = exp_q.pop_front();
            retired++;
          end
        end
        checkOutput("pc_valid", pc, cur.addr);
        checkOutput("instr", instr, cur.data);
        checkOutput("exc_adel", 32'(exc_adel), 32'(cur.exc));
        checkOutput("req_in_valid", 32'(imem_req), 32'h0);
        pred_valid = stall;
      end else begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL fetch_no_exp: got fetch at %h, expected none", pc);
          pred_valid = imem_ready;
        end else begin
          checkOutput("pc_fetch", pc, exp_q[0].addr);
          checkOutput("imem_addr", imem_addr, exp_q[0].addr);
          checkOutput("imem_req", 32'(imem_req), 32'(!exp_q[0].exc));
          checkOutput("exc_in_fetch", 32'(exc_adel), 32'h0);
          pred_valid = imem_ready || exp_q[0].exc;
        end
      end
      have_pred  = 1'b1;
      prev_valid = instr_valid;
    end
  end

  initial begin
    int n;
    reset      = 1'b1;
    npc        = 32'h0;
    stall      = 1'b0;
    imem_ready = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    #1;
    checkResetState();
    repeat (2) @(posedge clk);
    #1;
    checkResetState();

    mon_en = 1'b1;
    restartAfterReset();
    runRandom(80, 4000);

    // Steer the PC to 0x3010, hold ready low there, then reset between edges.
    hold_at_3010 = 1'b1;
    n = 0;
    while (!(imem_req && imem_addr == 32'h0000_3010 && !instr_valid) && n < 60) begin
      @(posedge clk);
      #1;
      applyStimulus();
      n++;
    end
    checkOutput("reach_3010", imem_addr, 32'h0000_3010);
    @(posedge clk);
    #1;
    applyStimulus();
    checkOutput("pre_reset_req", 32'(imem_req), 32'h1);
    #2;
    reset = 1'b1;
    #1;
    checkResetState();
    hold_at_3010 = 1'b0;
    @(posedge clk);
    #1;
    restartAfterReset();
    runRandom(retired + 30, 3000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
